// File: rtl/cross_strobe_rx_multi_if.sv
// Event handoff port of the multi-channel strobe receiver.
// The producer drives valid/chan and the consumer answers with ready.
interface cross_strobe_rx_multi_if #(
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic            evt_valid;
    logic [CH_W-1:0] evt_chan;
    logic            evt_ready;

    modport master (output evt_valid, output evt_chan, input evt_ready);
    modport slave  (input evt_valid, input evt_chan, output evt_ready);
endinterface

// File: rtl/cross_strobe_rx_multi.sv
// Receives toggle-encoded strobes from a foreign clock domain on CHANNELS lanes.
// Detected events are counted per lane and handed out round-robin over a valid/ready port.
module cross_strobe_rx_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [CHANNELS-1:0]       din_togl,
    output logic [CHANNELS-1:0]       dout_pulse,
    cross_strobe_rx_multi_if.master   evt,
    output logic [CHANNELS-1:0]       ovf,
    input  logic [CHANNELS-1:0]       ovf_clr
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WARM   = SYNC_STAGES + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sync_r [CHANNELS];
    logic                   hist_r [CHANNELS];
    logic [CNT_W-1:0]       cnt_r  [CHANNELS];
    logic                   ovf_r  [CHANNELS];
    logic [CHANNELS-1:0]    dec_s;
    logic [CHANNELS-1:0]    elig_s;
    logic [WARM_W-1:0]      warm_r;
    logic                   armed_s;
    logic                   hs_s;
    state_t                 state_r, state_nx;
    logic [CH_W-1:0]        chan_r, chan_nx;
    logic [CH_W-1:0]        rr_r, rr_nx;

    assign armed_s = (warm_r == WARM_W'(WARM));
    assign hs_s    = (state_r == OFFER) && evt.evt_ready;

    // Warm-up counter: pulses stay masked until the synchronisers hold settled input levels.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            warm_r <= {WARM_W{1'b0}};
        end else if (!armed_s) begin
            warm_r <= warm_r + WARM_W'(1);
        end else begin
            warm_r <= warm_r;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic sync_last_s;
        logic set_ovf_s;

        assign sync_last_s   = sync_r[c][SYNC_STAGES-1];
        assign dout_pulse[c] = armed_s & (sync_last_s ^ hist_r[c]);
        assign dec_s[c]      = hs_s && (chan_r == CH_W'(c));
        // An in-flight handshake on this lane does not count toward the next grant.
        assign elig_s[c]     = ((cnt_r[c] - CNT_W'(dec_s[c])) != {CNT_W{1'b0}});
        assign set_ovf_s     = dout_pulse[c] && !dec_s[c] && (cnt_r[c] == {CNT_W{1'b1}});
        assign ovf[c]        = ovf_r[c];

        // Synchroniser chain plus history flop for edge detection.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                sync_r[c] <= {SYNC_STAGES{1'b0}};
                hist_r[c] <= 1'b0;
            end else begin
                sync_r[c] <= {sync_r[c][SYNC_STAGES-2:0], din_togl[c]};
                hist_r[c] <= sync_last_s;
            end
        end

        // Saturating pending-event counter and sticky overflow flag (set beats clear).
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                cnt_r[c] <= {CNT_W{1'b0}};
                ovf_r[c] <= 1'b0;
            end else begin
                if (dout_pulse[c] && !dec_s[c]) begin
                    cnt_r[c] <= set_ovf_s ? cnt_r[c] : cnt_r[c] + CNT_W'(1);
                end else if (dec_s[c] && !dout_pulse[c]) begin
                    cnt_r[c] <= cnt_r[c] - CNT_W'(1);
                end else begin
                    cnt_r[c] <= cnt_r[c];
                end
                if (set_ovf_s) begin
                    ovf_r[c] <= 1'b1;
                end else if (ovf_clr[c]) begin
                    ovf_r[c] <= 1'b0;
                end else begin
                    ovf_r[c] <= ovf_r[c];
                end
            end
        end
    end

    // Offer state register with the granted channel and round-robin pointer.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= IDLE;
            chan_r  <= {CH_W{1'b0}};
            rr_r    <= {CH_W{1'b0}};
        end else begin
            state_r <= state_nx;
            chan_r  <= chan_nx;
            rr_r    <= rr_nx;
        end
    end

    // Next-state logic: round-robin search from rr_r, reloaded only when the port is free.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] grant;
        logic [CH_W-1:0] idx;
        found    = 1'b0;
        grant    = {CH_W{1'b0}};
        idx      = {CH_W{1'b0}};
        state_nx = state_r;
        chan_nx  = chan_r;
        rr_nx    = rr_r;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = CH_W'((int'(rr_r) + i) % CHANNELS);
            if (!found && elig_s[idx]) begin
                found = 1'b1;
                grant = idx;
            end else begin
                found = found;
            end
        end
        if ((state_r == IDLE) || evt.evt_ready) begin
            if (found) begin
                state_nx = OFFER;
                chan_nx  = grant;
                rr_nx    = CH_W'((int'(grant) + 1) % CHANNELS);
            end else begin
                state_nx = IDLE;
            end
        end else begin
            state_nx = state_r;
        end
    end

    // Port outputs come straight from registers.
    always_comb begin
        evt.evt_chan = chan_r;
        case (state_r)
            IDLE:    evt.evt_valid = 1'b0;
            OFFER:   evt.evt_valid = 1'b1;
            default: evt.evt_valid = 1'b0;
        endcase
    end
endmodule
